// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr, misaligned} between fetch and decode.
// Single-cycle flush on redirect; in_ready depends only on occupancy state.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_misaligned,
  input  logic            out_ready,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic            mis_mem_q   [DEPTH];

  logic push;
  logic pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Head entry is masked to zero while empty so stale storage never leaks out.
  assign out_pc         = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_instr      = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_misaligned = out_valid ? mis_mem_q[rd_ptr_q]   : 1'b0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; only occupied slots are ever presented.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
      mis_mem_q[wr_ptr_q]   <= (in_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/back-pressure, streaming wrap,
// flush priority, misaligned tagging, simultaneous push/pop and mid-stream reset.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misaligned;
  logic        out_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(4), .XLEN(32), .CW(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned),
    .out_ready      (out_ready),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = 32'h0000_1000 + pc;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset / idle
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_mis", 32'(out_misaligned), 32'd0);

    in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'h0000_0013;
    step();
    in_valid = 1'b0;
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_pc", out_pc, 32'h0);
    check("first_out_instr", out_instr, 32'h0000_0013);
    check("first_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("first_drain_count", 32'(count), 32'd0);
    check("first_drain_valid", 32'(out_valid), 32'd0);
    check("empty_out_pc_zero", out_pc, 32'h0);

    // Empty: out_ready ignored, no underflow
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("empty_no_underflow", 32'(count), 32'd0);

    // Fill and back-pressure
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i));
      step();
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    offer(32'h10);
    step();
    check("full_reject_count", 32'(count), 32'd4);
    check("full_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pop_from_full_count", 32'(count), 32'd3);
    check("pop_from_full_in_ready", 32'(in_ready), 32'd1);
    check("pop_from_full_head", out_pc, 32'h4);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check("drain_order_pc", out_pc, 32'(4 * i));
      check("drain_order_instr", out_instr, 32'h0000_1000 + 32'(4 * i));
      step();
    end
    check("drain_done_count", 32'(count), 32'd0);

    // Streaming with wrap (16 entries through a 4-deep ring)
    for (int i = 0; i < 16; i++) begin
      offer(32'(4 * i));
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", out_pc, 32'(4 * i));
      check("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);

    // Flush priority over push and pop
    for (int i = 0; i < 3; i++) begin
      offer(32'(4 * i));
      step();
    end
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; offer(32'h40); out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_pc", out_pc, 32'h0);
    offer(32'h80);
    step();
    in_valid = 1'b0;
    check("post_flush_pc", out_pc, 32'h80);
    check("post_flush_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Misaligned tagging
    offer(32'h6);
    step();
    offer(32'h8);
    step();
    in_valid = 1'b0;
    check("mis_pc6", out_pc, 32'h6);
    check("mis_flag6", 32'(out_misaligned), 32'd1);
    out_ready = 1'b1;
    step();
    check("mis_pc8", out_pc, 32'h8);
    check("mis_flag8", 32'(out_misaligned), 32'd0);
    step();
    out_ready = 1'b0;
    check("mis_drain_count", 32'(count), 32'd0);

    // Simultaneous push/pop at count 2
    offer(32'h100);
    step();
    offer(32'h104);
    step();
    check("pp_pre_count", 32'(count), 32'd2);
    offer(32'h108); out_ready = 1'b1;
    step();
    check("pp_count_a", 32'(count), 32'd2);
    check("pp_head_a", out_pc, 32'h104);
    offer(32'h10C);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_count_b", 32'(count), 32'd2);
    check("pp_head_b", out_pc, 32'h108);

    // Reset mid-stream
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    offer(32'h200);
    step();
    in_valid = 1'b0;
    check("post_rst_pc", out_pc, 32'h200);
    check("post_rst_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
